// File: rtl/inst_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_sram_responder_if
// Description : Bus bundle between the fetch stage (master) and the
//               instruction-SRAM responder (slave), including the
//               responder's backing-memory read port.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_sram_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int LAT_W  = 4
);
    // Fetch-side request/response handshake
    logic              req_i;
    logic [ADDR_W-1:0] addr_i;
    logic              addr_ok_o;
    logic              data_ok_o;
    logic [DATA_W-1:0] rdata_o;
    logic [LAT_W-1:0]  lat_cfg_i;

    // Backing-memory read port (synchronous read, data one cycle later)
    logic              mem_en_o;
    logic [ADDR_W-4:0] mem_addr_o;
    logic [DATA_W-1:0] mem_rdata_i;

    // Responder side
    modport slave (
        input  req_i, addr_i, lat_cfg_i, mem_rdata_i,
        output addr_ok_o, data_ok_o, rdata_o, mem_en_o, mem_addr_o
    );

    // Fetch stage plus memory model side
    modport master (
        output req_i, addr_i, lat_cfg_i, mem_rdata_i,
        input  addr_ok_o, data_ok_o, rdata_o, mem_en_o, mem_addr_o
    );
endinterface
`default_nettype wire

// File: rtl/inst_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : inst_sram_responder
// Description : Responder end of the instruction-SRAM-like fetch interface.
//               Accepts read requests into an in-order queue, reads 64-bit
//               instruction pairs from a synchronous-read memory and returns
//               each one with a single-cycle data_ok pulse after a
//               programmable extra delay.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_sram_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int QDEPTH = 2,
    parameter int LAT_W  = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    inst_sram_responder_if.slave    bus
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_WA_W  = ADDR_W - 3;                          // doubleword address width
    localparam int c_PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;   // queue pointer width
    localparam int c_CNT_W = $clog2(QDEPTH + 1);                  // occupancy counter width

    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(QDEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(QDEPTH - 1);

    // ------------------------------------------------------------------------
    // FSM encoding
    //   IDLE : waiting for a queued request, samples the latency setting
    //   WAIT : burning the extra latency cycles
    //   RD   : memory read issued for the head entry
    //   CAP  : memory data captured into the response register, head popped
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RD   = 2'd2,
        S_CAP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [c_WA_W-1:0]  r_queue [QDEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LAT_W-1:0]   r_wait_cnt;
    logic [LAT_W-1:0]   w_wait_cnt_nxt;

    logic               r_data_ok;
    logic [DATA_W-1:0]  r_rdata;

    logic               w_addr_ok;
    logic               w_push;
    logic               w_pop;
    logic               w_unused_addr_lsb;

    // Circular pointer advance; QDEPTH need not fill the pointer range.
    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : (p + c_PTR_W'(1));
    endfunction

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    // Acceptance depends only on occupancy, never on req_i, and is forced low
    // while reset is asserted.
    assign w_addr_ok = !rst && (r_count != c_FULL);
    assign w_push    = bus.req_i && w_addr_ok;
    // The head leaves the queue in the same cycle its data is captured.
    assign w_pop     = (r_state == S_CAP);

    // Byte offset within the doubleword is meaningless for this port.
    assign w_unused_addr_lsb = ^bus.addr_i[2:0];

    // ------------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------------
    // Store accepted doubleword addresses in arrival order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_queue[i] <= '0;
            end
        end else if (w_push) begin
            r_queue[r_wr_ptr] <= bus.addr_i[ADDR_W-1:3];
        end
    end

    // Pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Service FSM
    // ------------------------------------------------------------------------
    // State and wait-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Next-state logic; the latency setting is sampled only when leaving IDLE
    // so later changes cannot stretch or shorten a wait already in progress.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    if (bus.lat_cfg_i == '0) begin
                        w_state_nxt = S_RD;
                    end else begin
                        w_wait_cnt_nxt = bus.lat_cfg_i - LAT_W'(1);
                        w_state_nxt    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt = S_RD;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - LAT_W'(1);
                end
            end
            S_RD: begin
                w_state_nxt = S_CAP;
            end
            S_CAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Response register
    // ------------------------------------------------------------------------
    // Capture memory data in CAP; data_ok pulses for the following cycle only
    // and rdata holds until the next response overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_ok <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_data_ok <= (r_state == S_CAP);
            if (r_state == S_CAP) begin
                r_rdata <= bus.mem_rdata_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.addr_ok_o  = w_addr_ok;
    assign bus.data_ok_o  = r_data_ok;
    assign bus.rdata_o    = r_rdata;
    // Memory address always presents the head so it is stable going into RD.
    assign bus.mem_en_o   = (r_state == S_RD);
    assign bus.mem_addr_o = r_queue[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_inst_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_sram_responder
// Description : Self-checking bench for inst_sram_responder. A transaction
//               level model (queue of accepted addresses plus the scheduled
//               read cycle of the head) predicts every output each cycle;
//               directed sequences pin exact cycle numbers with literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_sram_responder;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int QDEPTH = 2;
    localparam int LAT_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    inst_sram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT_W(LAT_W)) bus ();

    inst_sram_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .QDEPTH (QDEPTH),
        .LAT_W  (LAT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory contents: one fixed instruction pair, the rest derived from address.
    function automatic logic [63:0] mem_word(input logic [28:0] a);
        if (a == 29'h3800001) return 64'h02800C0002800400;
        return {3'b101, a, 3'b010, a ^ 29'h0ABCDEF};
    endfunction

    // Synchronous-read backing memory.
    always @(posedge clk) begin
        if (bus.mem_en_o) bus.mem_rdata_i <= mem_word(bus.mem_addr_o);
    end

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------------
    // Reference model and per-cycle compare
    // ------------------------------------------------------------------------
    logic [28:0] mq[$];        // accepted, not yet popped, in order
    int          cur_rd = -1;  // cycle the head is read from memory, -1 if unscheduled
    int          cyc    = 0;
    bit          exp_dok = 1'b0;
    logic [63:0] exp_rdata = '0;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            cur_rd    = -1;
            exp_dok   = 1'b0;
            exp_rdata = '0;
            chk("rst_addr_ok", {63'd0, bus.addr_ok_o}, 64'd0);
            chk("rst_data_ok", {63'd0, bus.data_ok_o}, 64'd0);
            chk("rst_mem_en",  {63'd0, bus.mem_en_o},  64'd0);
            chk("rst_mem_addr", {35'd0, bus.mem_addr_o}, 64'd0);
            chk("rst_rdata",   bus.rdata_o, 64'd0);
        end else begin
            // Idle responder with work: schedule the read after the sampled latency.
            if (cur_rd < 0 && mq.size() != 0) cur_rd = cyc + 1 + int'(bus.lat_cfg_i);
            chk("m_addr_ok", {63'd0, bus.addr_ok_o}, {63'd0, mq.size() != QDEPTH});
            chk("m_mem_en",  {63'd0, bus.mem_en_o},  {63'd0, cyc == cur_rd});
            if (mq.size() != 0) chk("m_mem_addr", {35'd0, bus.mem_addr_o}, {35'd0, mq[0]});
            chk("m_data_ok", {63'd0, bus.data_ok_o}, {63'd0, exp_dok});
            chk("m_rdata",   bus.rdata_o, exp_rdata);
            exp_dok = 1'b0;
            if (bus.req_i && mq.size() != QDEPTH) mq.push_back(bus.addr_i[31:3]);
            if (cur_rd >= 0 && cyc == cur_rd + 1) begin
                exp_dok   = 1'b1;
                exp_rdata = mem_word(mq[0]);
                void'(mq.pop_front());
                cur_rd = -1;
            end
        end
        cyc++;
    end

    // ------------------------------------------------------------------------
    // Stimulus and literal expectations
    // ------------------------------------------------------------------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.req_i = 1'b0;
        repeat (n) nxt();
    endtask

    bit stall;

    initial begin
        bus.req_i     = 1'b0;
        bus.addr_i    = '0;
        bus.lat_cfg_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mid();
        chk("post_rst_addr_ok", {63'd0, bus.addr_ok_o}, 64'd1);
        idle(2);

        // Single read, lat=0: accept c0, RD c2, data_ok c4 only.
        bus.req_i = 1'b1; bus.addr_i = 32'h1C000008; bus.lat_cfg_i = '0;
        mid(); chk("t1_aok_c0", {63'd0, bus.addr_ok_o}, 64'd1); nxt();
        bus.req_i = 1'b0;
        mid(); chk("t1_en_c1", {63'd0, bus.mem_en_o}, 64'd0); nxt();
        mid(); chk("t1_en_c2", {63'd0, bus.mem_en_o}, 64'd1);
        chk("t1_maddr_c2", {35'd0, bus.mem_addr_o}, 64'h3800001); nxt();
        mid(); chk("t1_dok_c3", {63'd0, bus.data_ok_o}, 64'd0); nxt();
        mid(); chk("t1_dok_c4", {63'd0, bus.data_ok_o}, 64'd1);
        chk("t1_rdata_c4", bus.rdata_o, 64'h02800C0002800400); nxt();
        mid(); chk("t1_dok_c5", {63'd0, bus.data_ok_o}, 64'd0);
        chk("t1_rdata_c5", bus.rdata_o, 64'h02800C0002800400);
        idle(4);

        // Extra latency 3, changed to 0 mid-wait: RD c5, data_ok c7.
        bus.req_i = 1'b1; bus.addr_i = 32'h1C000008; bus.lat_cfg_i = 4'd3;
        nxt(); bus.req_i = 1'b0;
        nxt(); nxt(); bus.lat_cfg_i = 4'd0;           // cycle 3
        mid(); nxt();
        mid(); chk("t2_en_c4", {63'd0, bus.mem_en_o}, 64'd0); nxt();
        mid(); chk("t2_en_c5", {63'd0, bus.mem_en_o}, 64'd1); nxt();
        mid(); chk("t2_dok_c6", {63'd0, bus.data_ok_o}, 64'd0); nxt();
        mid(); chk("t2_dok_c7", {63'd0, bus.data_ok_o}, 64'd1);
        idle(4);

        // Queue full: 0x0, 0x8 accepted c0/c1; 0x10 held until c4.
        bus.lat_cfg_i = '0;
        bus.req_i = 1'b1; bus.addr_i = 32'h0; nxt();
        bus.addr_i = 32'h8; nxt();
        bus.addr_i = 32'h10;
        mid(); chk("t3_aok_c2", {63'd0, bus.addr_ok_o}, 64'd0); nxt();
        mid(); chk("t3_aok_c3", {63'd0, bus.addr_ok_o}, 64'd0); nxt();
        mid(); chk("t3_aok_c4", {63'd0, bus.addr_ok_o}, 64'd1);
        chk("t3_dok_c4", {63'd0, bus.data_ok_o}, 64'd1);
        chk("t3_rd0", bus.rdata_o, mem_word(29'd0)); nxt();
        bus.req_i = 1'b0; nxt(); nxt();
        mid(); chk("t3_dok_c7", {63'd0, bus.data_ok_o}, 64'd1);
        chk("t3_rd1", bus.rdata_o, mem_word(29'd1)); nxt();
        nxt(); nxt();
        mid(); chk("t3_dok_c10", {63'd0, bus.data_ok_o}, 64'd1);
        chk("t3_rd2", bus.rdata_o, mem_word(29'd2));
        idle(4);

        // Reset during WAIT (lat=5): nothing returned, then standard latency.
        bus.req_i = 1'b1; bus.addr_i = 32'h00000040; bus.lat_cfg_i = 4'd5;
        nxt(); bus.req_i = 1'b0;
        nxt(); nxt();
        rst = 1'b1;
        mid(); chk("t4_aok_rst", {63'd0, bus.addr_ok_o}, 64'd0); nxt();
        rst = 1'b0;
        mid(); chk("t4_aok_rel", {63'd0, bus.addr_ok_o}, 64'd1);
        idle(10);
        bus.req_i = 1'b1; bus.addr_i = 32'h00000048; bus.lat_cfg_i = '0;
        nxt(); bus.req_i = 1'b0; nxt();
        mid(); chk("t4_en_c2", {63'd0, bus.mem_en_o}, 64'd1); nxt();
        nxt();
        mid(); chk("t4_dok_c4", {63'd0, bus.data_ok_o}, 64'd1);
        chk("t4_rdata_c4", bus.rdata_o, mem_word(29'd9));
        idle(3);

        // Random requests, latencies and one reset pulse; requester holds a
        // stalled request, otherwise changes its mind freely.
        stall = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (i == 120) rst = 1'b1;
            else rst = 1'b0;
            if (!stall) begin
                bus.req_i  = ($urandom_range(0, 2) != 0);
                bus.addr_i = {$urandom_range(0, 32'h0FFF), 3'($urandom)} << 0;
            end
            bus.lat_cfg_i = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 6)) : 4'd0;
            mid();
            stall = bus.req_i && !bus.addr_ok_o;
            nxt();
        end
        rst = 1'b0;
        idle(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
